// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall controller bus: decoder-side hazard inputs toward the
// controller, stall/bubble/busy outputs back to the pipeline.
// Optional macro HAZARD_PERF_CNT_EN adds the stall_cycles counter output.
interface hazard_stall_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [1:0]  id_tuse_rs;
    logic [1:0]  id_tuse_rt;
    logic        id_md_use;
    logic [4:0]  ex_wreg;
    logic [1:0]  ex_tnew;
    logic [4:0]  mem_wreg;
    logic [1:0]  mem_tnew;
    logic        ex_md_start;
    logic        ex_md_div;
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_clr;
    logic        md_busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    // Pipeline side: supplies hazard info, consumes stall controls
    modport master (
        output id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_md_use,
        output ex_wreg, ex_tnew, mem_wreg, mem_tnew, ex_md_start, ex_md_div,
        input  pc_en, if_id_en, id_ex_clr,
`ifdef HAZARD_PERF_CNT_EN
        input  stall_cycles,
`endif
        input  md_busy
    );

    // Controller side
    modport slave (
        input  id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_md_use,
        input  ex_wreg, ex_tnew, mem_wreg, mem_tnew, ex_md_start, ex_md_div,
        output pc_en, if_id_en, id_ex_clr,
`ifdef HAZARD_PERF_CNT_EN
        output stall_cycles,
`endif
        output md_busy
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/bubble controller for the 5-stage pipeline.
// Register hazards use the Tuse/Tnew model (per source, combinational);
// the multiply/divide unit is tracked by a busy down-counter FSM.
// Optional macro HAZARD_PERF_CNT_EN adds a 32-bit wrapping stall cycle counter.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4   // must hold max(MULT_CYCLES, DIV_CYCLES)
) (
    input  logic                clk,
    input  logic                reset,
    hazard_stall_ctrl_if.slave  bus
);
    localparam int NUM_SRC = 2;  // source 0 = rs, source 1 = rt

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

    md_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   md_busy_q, md_busy_d;

    logic [NUM_SRC-1:0][4:0] src_idx;
    logic [NUM_SRC-1:0][1:0] src_tuse;
    logic [NUM_SRC-1:0]      src_haz;
    logic                    md_haz;
    logic                    stall;

    assign src_idx  = {bus.id_rt, bus.id_rs};
    assign src_tuse = {bus.id_tuse_rt, bus.id_tuse_rs};

    // Per-source hazard: a producer still in flight whose result is due
    // later than this source is needed. Index 0 is never a real dependency.
    // Tuse=3 can never be exceeded by Tnew<=2, so unused sources drop out.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign src_haz[g] = (src_idx[g] != 5'd0) &&
            ((bus.ex_wreg  == src_idx[g] && bus.ex_tnew  > src_tuse[g]) ||
             (bus.mem_wreg == src_idx[g] && bus.mem_tnew > src_tuse[g]));
    end

    // Stall decision: MD users wait while the unit runs, including the
    // start cycle itself which the registered busy flag does not yet show.
    always_comb begin
        md_haz = bus.id_md_use && (md_busy_q || bus.ex_md_start);
        stall  = (|src_haz) || md_haz;
    end

    assign bus.pc_en     = !stall;
    assign bus.if_id_en  = !stall;
    assign bus.id_ex_clr = stall;
    assign bus.md_busy   = md_busy_q;

    // MD busy counter next state; a start while busy is ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (bus.ex_md_start) begin
                    cnt_d   = bus.ex_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = MD_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = MD_IDLE;
            end
        endcase
        md_busy_d = (state_d == MD_BUSY);
    end

    // MD FSM registers with registered busy output
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            md_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            md_busy_q <= md_busy_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Stall cycle count, wraps naturally at 2^32
    always_comb begin
        stall_cycles_d = stall ? stall_cycles_q + 32'd1 : stall_cycles_q;
    end

    // Perf counter register
    always_ff @(posedge clk) begin
        if (reset) stall_cycles_q <= '0;
        else       stall_cycles_q <= stall_cycles_d;
    end

    assign bus.stall_cycles = stall_cycles_q;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: expected outputs from a small
// reference model are queued when stimulus is applied and compared when
// the DUT outputs are sampled mid-cycle.
module tb_hazard_stall_ctrl;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    typedef struct {
        logic [4:0] id_rs, id_rt;
        logic [1:0] id_tuse_rs, id_tuse_rt;
        logic       id_md_use;
        logic [4:0] ex_wreg;
        logic [1:0] ex_tnew;
        logic [4:0] mem_wreg;
        logic [1:0] mem_tnew;
        logic       ex_md_start, ex_md_div;
        logic       rst;
    } stim_t;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   m_cnt  = 0;
    logic [31:0] m_perf = '0;
    logic [3:0]  sb_q[$];

    hazard_stall_ctrl_if bus();

    hazard_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.id_rs = 0; s.id_rt = 0; s.id_tuse_rs = 3; s.id_tuse_rt = 3;
        s.id_md_use = 0; s.ex_wreg = 0; s.ex_tnew = 0; s.mem_wreg = 0;
        s.mem_tnew = 0; s.ex_md_start = 0; s.ex_md_div = 0; s.rst = 0;
        return s;
    endfunction

    function automatic logic src_haz(logic [4:0] idx, logic [1:0] tuse, stim_t s);
        if (idx == 0) return 1'b0;
        if (s.ex_wreg == idx && int'(s.ex_tnew) > int'(tuse)) return 1'b1;
        if (s.mem_wreg == idx && int'(s.mem_tnew) > int'(tuse)) return 1'b1;
        return 1'b0;
    endfunction

    // Expected {pc_en, if_id_en, id_ex_clr, md_busy}
    function automatic logic [3:0] model_out(stim_t s);
        logic busy, st;
        busy = (m_cnt != 0);
        st = src_haz(s.id_rs, s.id_tuse_rs, s) || src_haz(s.id_rt, s.id_tuse_rt, s) ||
             (s.id_md_use && (busy || s.ex_md_start));
        return {!st, !st, st, busy};
    endfunction

    // One cycle: apply, queue expectation, sample at negedge, advance model at posedge
    task automatic step(input stim_t s, input string tag, output logic [3:0] got);
        logic [3:0] e;
        bus.id_rs = s.id_rs; bus.id_rt = s.id_rt;
        bus.id_tuse_rs = s.id_tuse_rs; bus.id_tuse_rt = s.id_tuse_rt;
        bus.id_md_use = s.id_md_use; bus.ex_wreg = s.ex_wreg; bus.ex_tnew = s.ex_tnew;
        bus.mem_wreg = s.mem_wreg; bus.mem_tnew = s.mem_tnew;
        bus.ex_md_start = s.ex_md_start; bus.ex_md_div = s.ex_md_div;
        reset = s.rst;
        #1;
        sb_q.push_back(model_out(s));
        @(negedge clk);
        got = {bus.pc_en, bus.if_id_en, bus.id_ex_clr, bus.md_busy};
        e = sb_q.pop_front();
        chk(tag, {28'd0, got}, {28'd0, e});
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, "_perf"}, bus.stall_cycles, m_perf);
`endif
        @(posedge clk);
        if (s.rst) begin
            m_cnt = 0; m_perf = '0;
        end else begin
            if (e[1]) m_perf = m_perf + 32'd1;
            if (m_cnt > 0) m_cnt--;
            else if (s.ex_md_start) m_cnt = s.ex_md_div ? DIV_N : MULT_N;
        end
        #1;
    endtask

    initial begin
        stim_t s;
        logic [3:0] got;
        int busy_n, stall_n;
        logic [31:0] perf0;

        s = idle();
        bus.id_rs = 0; bus.id_rt = 0; bus.id_tuse_rs = 3; bus.id_tuse_rt = 3;
        bus.id_md_use = 0; bus.ex_wreg = 0; bus.ex_tnew = 0; bus.mem_wreg = 0;
        bus.mem_tnew = 0; bus.ex_md_start = 0; bus.ex_md_div = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state with all-zero inputs
        s = idle(); s.rst = 1; s.id_tuse_rs = 0; s.id_tuse_rt = 0;
        step(s, "reset", got);
        chk("reset_out", {28'd0, got}, 32'b1100);

        // Load-use
        s = idle(); s.id_rs = 5; s.id_tuse_rs = 0; s.ex_wreg = 5; s.ex_tnew = 2;
        step(s, "loaduse_ex", got);
        chk("loaduse_ex_abs", {28'd0, got}, 32'b0010);
        s = idle(); s.id_rs = 5; s.id_tuse_rs = 0; s.mem_wreg = 5; s.mem_tnew = 1;
        step(s, "loaduse_mem1", got);
        s.mem_tnew = 0;
        step(s, "loaduse_mem0", got);

        // Forwardable and $0
        s = idle(); s.id_rt = 8; s.id_tuse_rt = 1; s.ex_wreg = 8; s.ex_tnew = 1;
        step(s, "fwd_rt", got);
        s = idle(); s.id_rs = 0; s.id_tuse_rs = 0; s.ex_wreg = 0; s.ex_tnew = 2;
        step(s, "zero_reg", got);
        chk("zero_reg_abs", {28'd0, got}, 32'b1100);

        // Mult with MD user waiting throughout, plus a simultaneous reg hazard
        busy_n = 0; stall_n = 0;
`ifdef HAZARD_PERF_CNT_EN
        perf0 = bus.stall_cycles;
`else
        perf0 = '0;
`endif
        for (int i = 0; i <= MULT_N + 1; i++) begin
            s = idle(); s.id_md_use = 1; s.ex_md_start = (i == 0);
            if (i == 2) begin s.id_rs = 3; s.id_tuse_rs = 0; s.ex_wreg = 3; s.ex_tnew = 2; end
            step(s, "mult", got);
            busy_n += int'(got[0]);
            stall_n += int'(got[1]);
        end
        chk("mult_busy_cycles", busy_n, MULT_N);
        chk("mult_stall_cycles", stall_n, MULT_N + 1);
`ifdef HAZARD_PERF_CNT_EN
        chk("mult_perf_delta", bus.stall_cycles - perf0, MULT_N + 1);
`endif

        // Div with spurious start at busy cycle 3
        busy_n = 0;
        for (int i = 0; i <= DIV_N + 1; i++) begin
            s = idle(); s.ex_md_div = 1; s.ex_md_start = (i == 0 || i == 3);
            step(s, "div", got);
            if (i > 0) busy_n += int'(got[0]);
            if (i == DIV_N) chk("div_last_busy", {31'd0, got[0]}, 1);
            if (i == DIV_N + 1) chk("div_done", {31'd0, got[0]}, 0);
        end
        chk("div_busy_cycles", busy_n, DIV_N);

        // Reset during a div at busy cycle 4
        for (int i = 0; i <= 5; i++) begin
            s = idle(); s.ex_md_div = 1; s.ex_md_start = (i == 0);
            s.rst = (i == 4); s.id_md_use = (i == 5);
            step(s, "div_rst", got);
            if (i == 5) chk("div_rst_after", {28'd0, got}, 32'b1100);
        end

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            s = idle();
            s.id_rs = 5'($urandom_range(0, 3)); s.id_rt = 5'($urandom_range(0, 3));
            s.id_tuse_rs = 2'($urandom_range(0, 3)); s.id_tuse_rt = 2'($urandom_range(0, 3));
            s.id_md_use = 1'($urandom_range(0, 1));
            s.ex_wreg = 5'($urandom_range(0, 3)); s.ex_tnew = 2'($urandom_range(0, 2));
            s.mem_wreg = 5'($urandom_range(0, 3)); s.mem_tnew = 2'($urandom_range(0, 2));
            s.ex_md_start = ($urandom_range(0, 5) == 0); s.ex_md_div = 1'($urandom_range(0, 1));
            s.rst = ($urandom_range(0, 40) == 0);
            step(s, "rand", got);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
